decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL provide parameter FWD_EN, default 1; 1 enables EX/MEM forwarding, 0 always uses regfile data.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 in_valid  in  1  fetch offers instruction
 in_ready  out  1  stage accepts instruction
 inst_i  in  32  instruction
 pc_i  in  XLEN  instruction address
 flush_i  in  1  kill input and output register
 rs1_addr_o  out  5  regfile read address 1, combinational from inst_i
 rs2_addr_o  out  5  regfile read address 2, combinational from inst_i
 rs1_rdata_i  in  XLEN  regfile data 1
 rs2_rdata_i  in  XLEN  regfile data 2
 ex_we_i  in  1  EX writes rd
 ex_waddr_i  in  5  EX rd
 ex_wdata_i  in  XLEN  EX result
 ex_is_load_i  in  1  EX instruction is a load
 mem_we_i  in  1  MEM writes rd
 mem_waddr_i  in  5  MEM rd
 mem_wdata_i  in  XLEN  MEM result
 out_valid  out  1  decoded bundle valid
 out_ready  in  1  EX accepts bundle
 inst_o  out  32  registered instruction
 pc_o  out  XLEN  registered pc
 op1_o  out  XLEN  operand 1
 op2_o  out  XLEN  operand 2
 imm_o  out  XLEN  sign-extended immediate
 rd_o  out  5  destination
 rd_we_o  out  1  register write enable
 csr_addr_o  out  12  inst[31:20] for SYSTEM, else 0
 csr_we_o  out  1  CSR write enable
 illegal_o  out  1  unsupported encoding
 stall_cnt_o  out  32  load-use stall cycles

Function
REQ-005 SHALL register all outputs except in_ready and rs*_addr_o; latency is 1 cycle from accept to out_valid.
REQ-006 SHALL set in_ready = (!out_valid | out_ready) & !load_use & !flush_i; accept = in_valid & in_ready.
REQ-007 SHALL, on accept, load the bundle and set out_valid=1; else if out_ready, clear out_valid; else hold every output unchanged.
REQ-008 SHALL assert load_use when ex_is_load_i & ex_we_i & ex_waddr_i!=0 & ex_waddr_i matches a used rs1 or rs2 of inst_i while in_valid=1; while it holds, insert bubbles (out_valid=0 after out_ready).
REQ-009 SHALL increment stall_cnt_o each cycle that load_use=1, saturating at 0xFFFFFFFF.
REQ-010 SHALL select source data with priority EX > MEM > regfile when FWD_EN=1; x0 reads 0 and is never forwarded.
REQ-011 SHALL sign-extend immediates to XLEN: I, S, B(bit0=0), J(bit0=0), U(inst[31:12]<<12).
REQ-012 SHALL form operands per class: OP-IMM/LOAD/JALR op1=rs1, op2=I-imm; OP/BRANCH/STORE op1=rs1, op2=rs2; LUI op1=0, op2=U-imm; AUIPC/JAL op1=pc, op2=imm.
REQ-013 SHALL set rd_we_o=1 only for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, CSR*, and W-forms, and 0 whenever rd=0.
REQ-014 SHALL, for CSRRW/S/C, set op1=rs1 data; for CSRRWI/SI/CI, set op1=zero-extended inst[19:15]; csr_we_o=1 in all six.
REQ-015 SHALL decode OP-IMM-32/OP-32 only when XLEN=64; when XLEN=32 they are illegal.
REQ-016 SHALL, for illegal encodings, set illegal_o=1, rd_we_o=0, csr_we_o=0, and still present out_valid.
REQ-017 SHALL, on flush_i, clear out_valid next cycle, drop inst_i; flush_i overrides load_use and accept.

Reset
REQ-018 SHALL, on rst, clear out_valid, illegal_o, rd_we_o, csr_we_o, stall_cnt_o, and all data outputs to 0; reset mid-transfer discards the bundle.

Verification
REQ-019 addi x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle out_valid=1, op2_o=0xFFFF_FFFF_FFFF_FFFF, rd_o=5, rd_we_o=1.
REQ-020 add x3,x1,x2; ex_we=1 waddr=1 wdata=7; mem_we=1 waddr=1 wdata=9 -> op1_o=7 (EX wins).
REQ-021 ex_is_load=1 waddr=2 for 2 cycles, inst uses rs2=x2 -> in_ready=0, 2 bubbles, stall_cnt_o=2.
REQ-022 out_ready=0 for 3 cycles with valid bundle -> outputs stable, in_ready=0; release -> one transfer.
REQ-023 XLEN=32, addiw (opcode 0x1B) -> illegal_o=1, rd_we_o=0.
REQ-024 flush_i with out_valid=1 and in_valid=1 -> next cycle out_valid=0, instruction not accepted.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32/RV64 integer instruction decode with EX/MEM operand
// forwarding, a load-use interlock and a one-entry valid/ready output register.
module decode_stage #(
  parameter int XLEN   = 64,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] rs2_rdata_i,
  input  logic            ex_we_i,
  input  logic [4:0]      ex_waddr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_load_i,
  input  logic            mem_we_i,
  input  logic [4:0]      mem_waddr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic [11:0]     csr_addr_o,
  output logic            csr_we_o,
  output logic            illegal_o,
  output logic [31:0]     stall_cnt_o
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rd_we;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic            illegal;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            dec_legal, dec_use_rs1, dec_use_rs2, dec_has_rd, dec_csr_we;
  logic [XLEN-1:0] dec_op1, dec_op2, dec_imm;
  logic [11:0]     dec_csr_addr;
  logic            load_use, accept;
  bundle_t         bundle_d, bundle_q;
  logic            out_valid_d, out_valid_q;
  logic [31:0]     stall_cnt_d, stall_cnt_q;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign rs1_a      = inst_i[19:15];
  assign rs2_a      = inst_i[24:20];
  assign rd_a       = inst_i[11:7];
  assign rs1_addr_o = rs1_a;
  assign rs2_addr_o = rs2_a;

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  // Source operand selection: x0 is hardwired zero, then EX beats MEM beats regfile.
  always_comb begin
    rs1_val = rs1_rdata_i;
    rs2_val = rs2_rdata_i;
    if (rs1_a == 5'd0) rs1_val = '0;
    else if (FWD_EN != 0 && ex_we_i && ex_waddr_i == rs1_a) rs1_val = ex_wdata_i;
    else if (FWD_EN != 0 && mem_we_i && mem_waddr_i == rs1_a) rs1_val = mem_wdata_i;
    if (rs2_a == 5'd0) rs2_val = '0;
    else if (FWD_EN != 0 && ex_we_i && ex_waddr_i == rs2_a) rs2_val = ex_wdata_i;
    else if (FWD_EN != 0 && mem_we_i && mem_waddr_i == rs2_a) rs2_val = mem_wdata_i;
  end

  // Instruction class decode: legality, register usage, operands and immediate.
  always_comb begin
    dec_legal    = 1'b1;
    dec_use_rs1  = 1'b0;
    dec_use_rs2  = 1'b0;
    dec_has_rd   = 1'b0;
    dec_csr_we   = 1'b0;
    dec_op1      = '0;
    dec_op2      = '0;
    dec_imm      = '0;
    dec_csr_addr = '0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM32: begin
        dec_use_rs1 = 1'b1;
        dec_has_rd  = 1'b1;
        dec_op1     = rs1_val;
        dec_op2     = imm_i;
        dec_imm     = imm_i;
        if (opcode == OPC_LOAD)
          dec_legal = (funct3 != 3'd7) && (IS64 || (funct3 != 3'd3 && funct3 != 3'd6));
        else if (opcode == OPC_JALR)
          dec_legal = (funct3 == 3'd0);
        else if (opcode == OPC_OP_IMM32)
          dec_legal = IS64 && ((funct3 == 3'd0) || (funct3 == 3'd1 && funct7 == 7'h00) ||
                               (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)));
        else if (funct3 == 3'd1)
          dec_legal = IS64 ? (inst_i[31:26] == 6'h00) : (funct7 == 7'h00);
        else if (funct3 == 3'd5)
          dec_legal = IS64 ? (inst_i[31:26] == 6'h00 || inst_i[31:26] == 6'h10)
                           : (funct7 == 7'h00 || funct7 == 7'h20);
      end
      OPC_OP, OPC_OP32: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_has_rd  = 1'b1;
        dec_op1     = rs1_val;
        dec_op2     = rs2_val;
        if (opcode == OPC_OP)
          dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
        else
          dec_legal = IS64 &&
                      ((funct7 == 7'h00 && (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5)) ||
                       (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OPC_BRANCH, OPC_STORE: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_op1     = rs1_val;
        dec_op2     = rs2_val;
        if (opcode == OPC_BRANCH) begin
          dec_imm   = imm_b;
          dec_legal = (funct3 != 3'd2) && (funct3 != 3'd3);
        end else begin
          dec_imm   = imm_s;
          dec_legal = (funct3 < 3'd3) || (IS64 && funct3 == 3'd3);
        end
      end
      OPC_LUI: begin
        dec_has_rd = 1'b1;
        dec_op2    = imm_u;
        dec_imm    = imm_u;
      end
      OPC_AUIPC: begin
        dec_has_rd = 1'b1;
        dec_op1    = pc_i;
        dec_op2    = imm_u;
        dec_imm    = imm_u;
      end
      OPC_JAL: begin
        dec_has_rd = 1'b1;
        dec_op1    = pc_i;
        dec_op2    = imm_j;
        dec_imm    = imm_j;
      end
      OPC_MISC_MEM: dec_legal = (funct3 == 3'd0) || (funct3 == 3'd1);
      OPC_SYSTEM: begin
        dec_csr_addr = inst_i[31:20];
        dec_imm      = imm_i;
        if (funct3 == 3'd4) begin
          dec_legal = 1'b0;
        end else if (funct3 != 3'd0) begin
          dec_has_rd = 1'b1;
          dec_csr_we = 1'b1;
          if (funct3[2]) begin
            dec_op1 = XLEN'(rs1_a);
          end else begin
            dec_use_rs1 = 1'b1;
            dec_op1     = rs1_val;
          end
        end
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_use_rs1  = 1'b0;
      dec_use_rs2  = 1'b0;
      dec_has_rd   = 1'b0;
      dec_csr_we   = 1'b0;
      dec_op1      = '0;
      dec_op2      = '0;
      dec_imm      = '0;
      dec_csr_addr = '0;
    end
  end

  assign load_use = in_valid && ex_is_load_i && ex_we_i && (ex_waddr_i != 5'd0) &&
                    ((dec_use_rs1 && ex_waddr_i == rs1_a) || (dec_use_rs2 && ex_waddr_i == rs2_a));
  assign in_ready = (!out_valid_q || out_ready) && !load_use && !flush_i;
  assign accept   = in_valid && in_ready;

  // Output register next state: flush kills, accept loads, consume empties, otherwise hold.
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d       = 1'b1;
      bundle_d.inst     = inst_i;
      bundle_d.pc       = pc_i;
      bundle_d.op1      = dec_op1;
      bundle_d.op2      = dec_op2;
      bundle_d.imm      = dec_imm;
      bundle_d.rd       = dec_has_rd ? rd_a : 5'd0;
      bundle_d.rd_we    = dec_has_rd && (rd_a != 5'd0);
      bundle_d.csr_addr = dec_csr_addr;
      bundle_d.csr_we   = dec_csr_we;
      bundle_d.illegal  = !dec_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load_use && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign inst_o      = bundle_q.inst;
  assign pc_o        = bundle_q.pc;
  assign op1_o       = bundle_q.op1;
  assign op2_o       = bundle_q.op2;
  assign imm_o       = bundle_q.imm;
  assign rd_o        = bundle_q.rd;
  assign rd_we_o     = bundle_q.rd_we;
  assign csr_addr_o  = bundle_q.csr_addr;
  assign csr_we_o    = bundle_q.csr_we;
  assign illegal_o   = bundle_q.illegal;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (RV64 with forwarding,
// plus an RV32 copy without forwarding fed the same stimulus).
module tb_decode_stage;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [11:0] csr_addr;
    logic        csr_we, illegal;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, flush_i, out_valid, out_ready;
  logic [31:0] inst_i, inst_o, stall_cnt_o;
  logic [63:0] pc_i, rs1_rdata_i, rs2_rdata_i, ex_wdata_i, mem_wdata_i;
  logic [63:0] pc_o, op1_o, op2_o, imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, ex_waddr_i, mem_waddr_i, rd_o;
  logic        ex_we_i, ex_is_load_i, mem_we_i, rd_we_o, csr_we_o, illegal_o;
  logic [11:0] csr_addr_o;

  logic        in_ready_32, out_valid_32, rd_we_32, csr_we_32, illegal_32;
  logic [4:0]  rs1_addr_32, rs2_addr_32, rd_32;
  logic [31:0] inst_32, pc_32, op1_32, op2_32, imm_32, stall_32;
  logic [11:0] csr_addr_32;

  exp_t exp_q[$];
  exp_t stim_exp;
  int   total = 0;
  int   bad   = 0;

  decode_stage #(.XLEN(64), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst_i(inst_i),
    .pc_i(pc_i), .flush_i(flush_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i), .ex_we_i(ex_we_i),
    .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o), .pc_o(pc_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  decode_stage #(.XLEN(32), .FWD_EN(0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32), .inst_i(inst_i),
    .pc_i(pc_i[31:0]), .flush_i(flush_i), .rs1_addr_o(rs1_addr_32), .rs2_addr_o(rs2_addr_32),
    .rs1_rdata_i(rs1_rdata_i[31:0]), .rs2_rdata_i(rs2_rdata_i[31:0]), .ex_we_i(ex_we_i),
    .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i[31:0]), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i[31:0]),
    .out_valid(out_valid_32), .out_ready(out_ready), .inst_o(inst_32), .pc_o(pc_32),
    .op1_o(op1_32), .op2_o(op2_32), .imm_o(imm_32), .rd_o(rd_32), .rd_we_o(rd_we_32),
    .csr_addr_o(csr_addr_32), .csr_we_o(csr_we_32), .illegal_o(illegal_32),
    .stall_cnt_o(stall_32)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic exp_t mk(input logic [31:0] inst, input logic [63:0] pc, op1, op2, imm,
                              input logic [4:0] rd, input logic we, input logic [11:0] csr,
                              input logic cwe, input logic ill);
    exp_t e;
    e.inst = inst; e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm; e.rd = rd;
    e.rd_we = we; e.csr_addr = csr; e.csr_we = cwe; e.illegal = ill;
    return e;
  endfunction

  // Advance one clock: consume a presented bundle against the scoreboard, record an accept.
  task automatic step();
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got bundle inst=%h, required none", inst_o);
      end else begin
        e = exp_q.pop_front();
        total += 10;
        if (inst_o !== e.inst) begin bad++; $display("[TB] FAIL sb_inst: got %h, required %h", inst_o, e.inst); end
        if (pc_o !== e.pc) begin bad++; $display("[TB] FAIL sb_pc: got %h, required %h", pc_o, e.pc); end
        if (op1_o !== e.op1) begin bad++; $display("[TB] FAIL sb_op1 inst=%h: got %h, required %h", e.inst, op1_o, e.op1); end
        if (op2_o !== e.op2) begin bad++; $display("[TB] FAIL sb_op2 inst=%h: got %h, required %h", e.inst, op2_o, e.op2); end
        if (imm_o !== e.imm) begin bad++; $display("[TB] FAIL sb_imm inst=%h: got %h, required %h", e.inst, imm_o, e.imm); end
        if (rd_o !== e.rd) begin bad++; $display("[TB] FAIL sb_rd inst=%h: got %0d, required %0d", e.inst, rd_o, e.rd); end
        if (rd_we_o !== e.rd_we) begin bad++; $display("[TB] FAIL sb_rd_we inst=%h: got %b, required %b", e.inst, rd_we_o, e.rd_we); end
        if (csr_addr_o !== e.csr_addr) begin bad++; $display("[TB] FAIL sb_csr_addr inst=%h: got %h, required %h", e.inst, csr_addr_o, e.csr_addr); end
        if (csr_we_o !== e.csr_we) begin bad++; $display("[TB] FAIL sb_csr_we inst=%h: got %b, required %b", e.inst, csr_we_o, e.csr_we); end
        if (illegal_o !== e.illegal) begin bad++; $display("[TB] FAIL sb_illegal inst=%h: got %b, required %b", e.inst, illegal_o, e.illegal); end
      end
    end
    if (!rst && in_valid && in_ready) exp_q.push_back(stim_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid: got %b, required 0", out_valid); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL drain_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; inst_i = 32'hFFF00293;
    repeat (2) step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total += 7;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b, required 0", out_valid); end
    if (rd_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_we: got %b, required 0", rd_we_o); end
    if (illegal_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_illegal: got %b, required 0", illegal_o); end
    if (csr_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_csr_we: got %b, required 0", csr_we_o); end
    if (stall_cnt_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_stall: got %0d, required 0", stall_cnt_o); end
    if (inst_o !== 32'd0 || op2_o !== 64'd0) begin bad++; $display("[TB] FAIL rst_data: got inst=%h op2=%h, required 0", inst_o, op2_o); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_addi();
    inst_i = 32'hFFF00293; pc_i = 64'h1000; rs1_rdata_i = 64'hDEAD; in_valid = 1'b1;
    stim_exp = mk(32'hFFF00293, 64'h1000, 64'd0, '1, '1, 5'd5, 1'b1, 12'h0, 1'b0, 1'b0);
    #1;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL addi_in_ready: got %b, required 1", in_ready); end
    if (rs1_addr_o !== 5'd0) begin bad++; $display("[TB] FAIL addi_rs1_addr: got %0d, required 0", rs1_addr_o); end
    if (rs2_addr_o !== 5'd31) begin bad++; $display("[TB] FAIL addi_rs2_addr: got %0d, required 31", rs2_addr_o); end
    step();
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid: got %b, required 1", out_valid); end
    if (op2_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL addi_op2: got %h, required ffffffffffffffff", op2_o); end
    if (rd_o !== 5'd5) begin bad++; $display("[TB] FAIL addi_rd: got %0d, required 5", rd_o); end
    if (rd_we_o !== 1'b1) begin bad++; $display("[TB] FAIL addi_rd_we: got %b, required 1", rd_we_o); end
    drain();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; out_ready = 1'b1;
    inst_i = 32'h002081B3; pc_i = 64'h100; rs1_rdata_i = 64'h11; rs2_rdata_i = 64'h22;
    ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 64'd7;
    mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 64'd9;
    stim_exp = mk(32'h002081B3, 64'h100, 64'd7, 64'h22, 64'd0, 5'd3, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    total += 2;
    if (op1_o !== 64'd7) begin bad++; $display("[TB] FAIL fwd_ex_wins: got %h, required 7", op1_o); end
    if (op1_32 !== 32'h11) begin bad++; $display("[TB] FAIL fwd_disabled: got %h, required 11", op1_32); end
    ex_waddr_i = 5'd4; mem_waddr_i = 5'd2; pc_i = 64'h104;
    stim_exp = mk(32'h002081B3, 64'h104, 64'h11, 64'd9, 64'd0, 5'd3, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    inst_i = 32'h002001B3; pc_i = 64'h108; rs1_rdata_i = 64'h55;
    ex_waddr_i = 5'd0; mem_waddr_i = 5'd0;
    stim_exp = mk(32'h002001B3, 64'h108, 64'd0, 64'h22, 64'd0, 5'd3, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    total++;
    if (op1_o !== 64'd0) begin bad++; $display("[TB] FAIL fwd_x0: got %h, required 0", op1_o); end
    ex_we_i = 1'b0; mem_we_i = 1'b0; ex_wdata_i = '0; mem_wdata_i = '0;
    drain();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; out_ready = 1'b1;
    inst_i = 32'h002081B3; pc_i = 64'h200; rs1_rdata_i = 64'h11; rs2_rdata_i = 64'h22;
    ex_is_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd2;
    for (int i = 1; i <= 2; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL lu_in_ready[%0d]: got %b, required 0", i, in_ready); end
      step();
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble[%0d]: got %b, required 0", i, out_valid); end
      if (stall_cnt_o !== 32'(i)) begin bad++; $display("[TB] FAIL lu_stall_cnt[%0d]: got %0d, required %0d", i, stall_cnt_o, i); end
    end
    ex_is_load_i = 1'b0; ex_we_i = 1'b0;
    stim_exp = mk(32'h002081B3, 64'h200, 64'h11, 64'h22, 64'd0, 5'd3, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lu_release: got %b, required 1", out_valid); end
    inst_i = 32'h00200293; pc_i = 64'h204;
    ex_is_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd2;
    stim_exp = mk(32'h00200293, 64'h204, 64'd0, 64'd2, 64'd2, 5'd5, 1'b1, 12'h0, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL lu_unused_rs2: got %b, required 1", in_ready); end
    step();
    total++;
    if (stall_cnt_o !== 32'd2) begin bad++; $display("[TB] FAIL lu_stall_hold: got %0d, required 2", stall_cnt_o); end
    ex_is_load_i = 1'b0; ex_we_i = 1'b0; ex_waddr_i = 5'd0;
    drain();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b0;
    inst_i = 32'h123453B7; pc_i = 64'h2000;
    stim_exp = mk(32'h123453B7, 64'h2000, 64'd0, 64'h12345000, 64'h12345000, 5'd7, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    inst_i = 32'h80000417; pc_i = 64'h2004;
    stim_exp = mk(32'h80000417, 64'h2004, 64'h2004, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
                  5'd8, 1'b1, 12'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready); end
      step();
      total++;
      if (out_valid !== 1'b1 || inst_o !== 32'h123453B7 || pc_o !== 64'h2000 || op2_o !== 64'h12345000) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b inst=%h pc=%h op2=%h, required 1 123453b7 2000 12345000",
                 i, out_valid, inst_o, pc_o, op2_o);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b, required 1", in_ready); end
    step();
    total++;
    if (out_valid !== 1'b1 || inst_o !== 32'h80000417) begin
      bad++; $display("[TB] FAIL bp_next: got valid=%b inst=%h, required 1 80000417", out_valid, inst_o);
    end
    drain();
  endtask

  task automatic test_classes();
    exp_t tbl[6];
    tbl[0] = mk(32'h300290F3, 64'h3000, 64'hABCD, 64'd0, 64'h300, 5'd1, 1'b1, 12'h300, 1'b1, 1'b0);
    tbl[1] = mk(32'h3058D073, 64'h3004, 64'd17, 64'd0, 64'h305, 5'd0, 1'b0, 12'h305, 1'b1, 1'b0);
    tbl[2] = mk(32'h0020B423, 64'h3008, 64'hABCD, 64'h1234, 64'd8, 5'd0, 1'b0, 12'h0, 1'b0, 1'b0);
    tbl[3] = mk(32'hFE208EE3, 64'h300C, 64'hABCD, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 1'b0, 12'h0, 1'b0, 1'b0);
    tbl[4] = mk(32'hFFFFFFFF, 64'h3010, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 12'h0, 1'b0, 1'b1);
    tbl[5] = mk(32'hFFE0831B, 64'h3014, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                5'd6, 1'b1, 12'h0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1; rs1_rdata_i = 64'hABCD; rs2_rdata_i = 64'h1234;
    for (int i = 0; i < 6; i++) begin
      inst_i = tbl[i].inst; pc_i = tbl[i].pc; stim_exp = tbl[i];
      ex_we_i = (i == 1); ex_waddr_i = (i == 1) ? 5'd17 : 5'd0; ex_wdata_i = 64'h999;
      step();
    end
    total += 4;
    if (illegal_32 !== 1'b1) begin bad++; $display("[TB] FAIL xlen32_addiw_illegal: got %b, required 1", illegal_32); end
    if (rd_we_32 !== 1'b0) begin bad++; $display("[TB] FAIL xlen32_addiw_rd_we: got %b, required 0", rd_we_32); end
    if (out_valid_32 !== 1'b1) begin bad++; $display("[TB] FAIL xlen32_addiw_valid: got %b, required 1", out_valid_32); end
    if (illegal_o !== 1'b0) begin bad++; $display("[TB] FAIL xlen64_addiw_legal: got %b, required 0", illegal_o); end
    ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = '0;
    drain();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0;
    inst_i = 32'hFFF00293; pc_i = 64'h4000;
    stim_exp = mk(32'hFFF00293, 64'h4000, 64'd0, '1, '1, 5'd5, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    inst_i = 32'h123453B7; pc_i = 64'h4004; flush_i = 1'b1;
    stim_exp = mk(32'h123453B7, 64'h4004, 64'd0, 64'h12345000, 64'h12345000, 5'd7, 1'b1, 12'h0, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready: got %b, required 0", in_ready); end
    step();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b, required 0", out_valid); end
    if (exp_q.size() != 1) begin bad++; $display("[TB] FAIL flush_queue: got %0d pending, required 1", exp_q.size()); end
    exp_q.delete();
    flush_i = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0;
    inst_i = 32'h123453B7; pc_i = 64'h5000;
    stim_exp = mk(32'h123453B7, 64'h5000, 64'd0, 64'h12345000, 64'h12345000, 5'd7, 1'b1, 12'h0, 1'b0, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rmid_loaded: got %b, required 1", out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    total += 3;
    if (out_valid !== 1'b0 || rd_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ctrl: got valid=%b rd_we=%b, required 0 0", out_valid, rd_we_o); end
    if (op2_o !== 64'd0 || inst_o !== 32'd0) begin bad++; $display("[TB] FAIL rmid_data: got op2=%h inst=%h, required 0 0", op2_o, inst_o); end
    if (stall_cnt_o !== 32'd0) begin bad++; $display("[TB] FAIL rmid_stall: got %0d, required 0", stall_cnt_o); end
    drain();
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
    inst_i = 32'h00000013; pc_i = '0; rs1_rdata_i = '0; rs2_rdata_i = '0;
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    stim_exp = mk('0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_backpressure();
    test_classes();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
